// File: rtl/ntt_mul_arbiter.sv
// Round-robin share of one combinational modular multiplier among NUM_REQ NTT requesters; owns the modulus register.
// Latency: an op granted in cycle c shows rsp_valid in cycle c+2; sustains one op per cycle.
// Backpressure: rsp_ready low freezes S2, then S1 and mul_*, and withdraws all grants once S1 is full.
// Optional: define MUL_ARB_STATS_EN to add the stat_ops / stat_stall saturating counters.
module ntt_mul_arbiter #(
    parameter int               NUM_REQ = 4,
    parameter int               DATA_W  = 32,
    parameter int               ID_W    = 2,
    parameter logic [DATA_W-1:0] RST_MOD = DATA_W'(7681)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_twiddle,
    input  logic                      cfg_we,
    input  logic [DATA_W-1:0]         cfg_modulus,
    output logic                      cfg_ack,
    output logic                      cfg_err,
    output logic [DATA_W-1:0]         mul_data_in,
    output logic [DATA_W-1:0]         mul_twiddle,
    output logic [DATA_W-1:0]         mul_modulus,
    input  logic [DATA_W-1:0]         mul_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [31:0]               stat_ops,
    output logic [31:0]               stat_stall
`endif
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   s1_id;
    logic              s1_valid;
    logic [DATA_W-1:0] modulus;
    logic              stall;
    logic              s1_load;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;

    assign mul_modulus = modulus;
    assign stall       = rsp_valid & ~rsp_ready;
    assign s1_load     = ~s1_valid | ~stall;

    // Round-robin search from rr_ptr; a pending modulus write blocks new grants so the pipe drains
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        if (s1_load && !cfg_we) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_vld) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    // Operand stage: captures the granted op, holds while S2 is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_id       <= '0;
            mul_data_in <= '0;
            mul_twiddle <= '0;
            rr_ptr      <= '0;
        end else if (s1_load) begin
            s1_valid <= grant_vld;
            if (grant_vld) begin
                s1_id       <= grant_idx;
                mul_data_in <= req_data[grant_idx*DATA_W +: DATA_W];
                mul_twiddle <= req_twiddle[grant_idx*DATA_W +: DATA_W];
                rr_ptr      <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
            end
        end
    end

    // Response stage: registers the multiplier output with its requester tag
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else if (!stall) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id     <= s1_id;
                rsp_result <= mul_result;
            end
        end
    end

    // Modulus update only with both stages empty, so no in-flight op sees a change
    always_ff @(posedge clk) begin
        if (rst) begin
            modulus <= RST_MOD;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_we && !s1_valid && !rsp_valid) begin
                if (cfg_modulus != '0) begin
                    modulus <= cfg_modulus;
                    cfg_ack <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

`ifdef MUL_ARB_STATS_EN
    // Saturating counters: delivered responses and stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready && stat_ops != '1) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if (stall && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_ntt_mul_arbiter.sv
// Scoreboard bench for ntt_mul_arbiter: accepted ops push expected responses, a monitor pops on rsp handshake.
// Directed sequences cover single ops, round-robin order, stall, modulus writes and mid-flight reset.
// Inputs change 2 time units after the rising edge; all sampling happens on the falling edge.
module tb_ntt_mul_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*DATA_W-1:0] req_twiddle;
    logic                      cfg_we;
    logic [DATA_W-1:0]         cfg_modulus;
    logic                      cfg_ack;
    logic                      cfg_err;
    logic [DATA_W-1:0]         mul_data_in;
    logic [DATA_W-1:0]         mul_twiddle;
    logic [DATA_W-1:0]         mul_modulus;
    logic [DATA_W-1:0]         mul_result;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;

    ntt_mul_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_twiddle(req_twiddle),
        .cfg_we(cfg_we), .cfg_modulus(cfg_modulus), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .mul_data_in(mul_data_in), .mul_twiddle(mul_twiddle), .mul_modulus(mul_modulus),
        .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared modular multiplier
    assign mul_result = DATA_W'((64'(mul_data_in) * 64'(mul_twiddle)) % 64'(mul_modulus));

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] res;
    } exp_t;

    exp_t   sb[$];
    int     glog[$];
    longint tb_mod = 7681;
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    longint dtab[4] = '{10, 11, 12, 13};
    longint ttab[4] = '{2, 3, 4, 5};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accepted op -> expected response computed from the driven operands and the bench modulus
    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] t;
        if (!rst) begin
            check("ready_legal", longint'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    d = req_data[i*DATA_W +: DATA_W];
                    t = req_twiddle[i*DATA_W +: DATA_W];
                    sb.push_back('{id: ID_W'(i), res: DATA_W'((longint'(d) * longint'(t)) % tb_mod)});
                    glog.push_back(i);
                end
            end
        end
    end

    // Response monitor: every delivered response must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", longint'(rsp_id), longint'(e.id));
                check("rsp_result", longint'(rsp_result), longint'(e.res));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cfg_we = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        sb.delete();
        glog.delete();
        tb_mod = 7681;
        rst = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W]    = DATA_W'(dtab[i]);
            req_twiddle[i*DATA_W +: DATA_W] = DATA_W'(ttab[i]);
        end
    endtask

    // Present one op on port p until granted; returns the cycle number of the grant
    task automatic single_op(input int p, input longint d, input longint t, output int acc_cyc);
        step();
        req_data[p*DATA_W +: DATA_W]    = DATA_W'(d);
        req_twiddle[p*DATA_W +: DATA_W] = DATA_W'(t);
        req_valid[p] = 1'b1;
        acc_cyc = -1;
        for (int k = 0; k < 50 && acc_cyc < 0; k++) begin
            @(negedge clk);
            if (req_ready[p]) acc_cyc = cyc;
        end
        step();
        req_valid[p] = 1'b0;
        if (acc_cyc < 0) check("grant_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check({name, "_drain"}, longint'(sb.size()), 0);
    endtask

    // Wait for the modulus write outcome and release cfg_we in the acknowledge cycle
    task automatic wait_cfg(output logic ack, output logic err);
        ack = 1'b0;
        err = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cfg_ack || cfg_err) begin
                ack = cfg_ack;
                err = cfg_err;
                req_valid = '0;
                cfg_we = 1'b0;
                return;
            end
        end
        check("cfg_timeout", 0, 1);
        req_valid = '0;
        cfg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int   acc;
        logic ack;
        logic err;
        logic [DATA_W-1:0] snap_res, snap_d, snap_t;
        logic [ID_W-1:0]   snap_id;

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_twiddle = '0;
        cfg_we = 1'b0;
        cfg_modulus = '0;
        rsp_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_req_ready", longint'(req_ready), 0);
        check("rst_rsp_valid", longint'(rsp_valid), 0);
        check("rst_rsp_id", longint'(rsp_id), 0);
        check("rst_rsp_result", longint'(rsp_result), 0);
        check("rst_cfg_ack", longint'(cfg_ack), 0);
        check("rst_cfg_err", longint'(cfg_err), 0);
        check("rst_mul_data_in", longint'(mul_data_in), 0);
        check("rst_mul_twiddle", longint'(mul_twiddle), 0);
        check("rst_mul_modulus", longint'(mul_modulus), 7681);
        do_reset();

        // Single op on port 0, response exactly two cycles after the grant cycle
        single_op(0, 6, 1, acc);
        @(negedge clk);
        check("lat_cyc1_rsp_valid", longint'(rsp_valid), 0);
        @(negedge clk);
        check("lat_cyc2_rsp_valid", longint'(rsp_valid), 1);
        check("t1_rsp_result", longint'(rsp_result), 6);
        drain("t1");

        // Single op on port 2 with large operands: 7679*4298 mod 7681 = 6766
        single_op(2, 7679, 4298, acc);
        drain("t2");

        // All ports valid from rr_ptr=0: grants 0,1,2,3,0,1,2,3, one per cycle
        do_reset();
        load_table();
        req_valid = '1;
        repeat (8) @(negedge clk);
        step();
        req_valid = '0;
        check("t3_grant_count", longint'(glog.size()), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            check("t3_grant_order", longint'(glog[i]), longint'(i % 4));
        end
        drain("t3");

        // Stall: rsp_ready low, S2 holds port0 op, S1 holds port1 op, no further grants
        step();
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) @(negedge clk);
        check("t4_rsp_valid", longint'(rsp_valid), 1);
        check("t4_rsp_id", longint'(rsp_id), 0);
        check("t4_mul_data_in", longint'(mul_data_in), dtab[1]);
        check("t4_mul_twiddle", longint'(mul_twiddle), ttab[1]);
        snap_res = rsp_result;
        snap_id = rsp_id;
        snap_d = mul_data_in;
        snap_t = mul_twiddle;
        repeat (3) begin
            @(negedge clk);
            check("t4_req_ready_blocked", longint'(req_ready), 0);
            check("t4_hold_rsp_result", longint'(rsp_result), longint'(snap_res));
            check("t4_hold_rsp_id", longint'(rsp_id), longint'(snap_id));
            check("t4_hold_mul_data_in", longint'(mul_data_in), longint'(snap_d));
            check("t4_hold_mul_twiddle", longint'(mul_twiddle), longint'(snap_t));
        end
        step();
        rsp_ready = 1'b1;
        req_valid = '0;
        drain("t4");

        // Modulus write during traffic: grants stop, pipe drains, then ack
        step();
        req_valid = '1;
        step();
        step();
        cfg_modulus = DATA_W'(17);
        cfg_we = 1'b1;
        @(negedge clk);
        check("t5_grant_blocked", longint'(req_ready), 0);
        wait_cfg(ack, err);
        check("t5_cfg_ack", longint'(ack), 1);
        check("t5_cfg_err", longint'(err), 0);
        check("t5_drained_before_ack", longint'(sb.size()), 0);
        check("t5_mul_modulus", longint'(mul_modulus), 17);
        tb_mod = 17;
        single_op(0, 5, 4, acc);
        drain("t5a");
        check("t5_last_result", longint'(rsp_result), 3);

        // Zero modulus is rejected and the old one kept
        step();
        cfg_modulus = '0;
        cfg_we = 1'b1;
        wait_cfg(ack, err);
        check("t5_zero_err", longint'(err), 1);
        check("t5_zero_ack", longint'(ack), 0);
        check("t5_zero_modulus", longint'(mul_modulus), 17);
        single_op(1, 10, 10, acc);
        drain("t5b");
        check("t5b_result", longint'(rsp_result), 15);

        // Reset with S1 and S2 full: everything cleared, port0 has priority, no stale response
        step();
        load_table();
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) @(negedge clk);
        check("t6_full_rsp_valid", longint'(rsp_valid), 1);
        step();
        rst = 1'b1;
        step();
        sb.delete();
        @(negedge clk);
        check("t6_rsp_valid", longint'(rsp_valid), 0);
        check("t6_req_ready_port0", longint'(req_ready), 1);
        check("t6_mul_modulus", longint'(mul_modulus), 7681);
        check("t6_mul_data_in", longint'(mul_data_in), 0);
        step();
        tb_mod = 7681;
        req_valid = '0;
        rsp_ready = 1'b1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t6_no_stale", longint'(rsp_valid), 0);
        end
        single_op(1, 7680, 7680, acc);
        drain("t6");
        check("t6_result", longint'(rsp_result), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
